// File: rtl/half_pel_pkg.sv
// rtl/half_pel_pkg.sv - shared FSM states, row geometry and phase constants for the half-pel collector
package half_pel_pkg;

    localparam int PIXEL_SIZE = 8;
    localparam int ROW_W      = 15 * PIXEL_SIZE;
    localparam int TAG_STRIDE = 8;

    localparam logic [1:0] PHASE_A = 2'd0;
    localparam logic [1:0] PHASE_B = 2'd1;
    localparam logic [1:0] PHASE_C = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL_A = 3'd1,
        FILL_B = 3'd2,
        FILL_C = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/half_pel_row_bank.sv
// rtl/half_pel_row_bank.sv - NUM_PIXEL x ROW_W register bank written one row at a time
module half_pel_row_bank #(
    parameter int NUM_PIXEL = 8,
    parameter int ROW_W     = 120,
    parameter int IDX_W     = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic [IDX_W-1:0]           idx,
    input  logic [ROW_W-1:0]           wdata,
    output logic [NUM_PIXEL*ROW_W-1:0] rows
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rows <= '0;
        end else if (we) begin
            rows[ROW_W*int'(idx) +: ROW_W] <= wdata;
        end
    end

endmodule

// File: rtl/half_pel_array_collector.sv
// rtl/half_pel_array_collector.sv - collects filtered rows into A/B/C half-pel arrays; HALF_PEL_SEL_CHECK_EN enables row-tag checking
module half_pel_array_collector
    import half_pel_pkg::*;
#(
    parameter int NUM_PIXEL = 8,
    parameter int ROW_W     = half_pel_pkg::ROW_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       first_round,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROW_W-1:0]           in_row,
    input  logic [7:0]                 in_sel,
    output logic [NUM_PIXEL*ROW_W-1:0] a_half_array,
    output logic [NUM_PIXEL*ROW_W-1:0] b_half_array,
    output logic [NUM_PIXEL*ROW_W-1:0] c_half_array,
    output logic                       done,
    output logic                       sel_err
);

    localparam int CNT_W = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIXEL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             sel_err_q, sel_err_d;
    logic             accept, tag_ok, write_en;
    logic [1:0]       phase;

    assign in_ready = (state_q == FILL_A) || (state_q == FILL_B) || (state_q == FILL_C);
    assign done     = (state_q == DONE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        phase = PHASE_A;
        case (state_q)
            FILL_B:  phase = PHASE_B;
            FILL_C:  phase = PHASE_C;
            default: phase = PHASE_A;
        endcase
    end

`ifdef HALF_PEL_SEL_CHECK_EN
    logic [7:0] exp_tag;
    assign exp_tag = 8'(cnt_q) + 8'(TAG_STRIDE * int'(phase));
    assign tag_ok  = (in_sel == exp_tag);
    assign sel_err = sel_err_q;
`else
    logic unused_sel;
    assign unused_sel = ^{in_sel, sel_err_q};
    assign tag_ok     = 1'b1;
    assign sel_err    = 1'b0;
`endif

    // start outranks a beat in the same cycle: the beat is neither written nor counted
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        sel_err_d = sel_err_q;
        write_en  = 1'b0;
        if (start) begin
            cnt_d     = '0;
            sel_err_d = 1'b0;
            first_d   = first_round;
            state_d   = first_round ? FILL_A : FILL_B;
        end else if (accept) begin
            if (!tag_ok) begin
                sel_err_d = 1'b1;
            end else begin
                write_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        FILL_A:  state_d = FILL_B;
                        FILL_B:  state_d = first_q ? FILL_C : DONE;
                        FILL_C:  state_d = DONE;
                        default: state_d = state_q;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            sel_err_q <= sel_err_d;
        end
    end

    half_pel_row_bank #(.NUM_PIXEL(NUM_PIXEL), .ROW_W(ROW_W), .IDX_W(CNT_W)) u_bank_a (
        .clock (clock),
        .reset (reset),
        .we    (write_en && (state_q == FILL_A)),
        .idx   (cnt_q),
        .wdata (in_row),
        .rows  (a_half_array)
    );

    half_pel_row_bank #(.NUM_PIXEL(NUM_PIXEL), .ROW_W(ROW_W), .IDX_W(CNT_W)) u_bank_b (
        .clock (clock),
        .reset (reset),
        .we    (write_en && (state_q == FILL_B)),
        .idx   (cnt_q),
        .wdata (in_row),
        .rows  (b_half_array)
    );

    half_pel_row_bank #(.NUM_PIXEL(NUM_PIXEL), .ROW_W(ROW_W), .IDX_W(CNT_W)) u_bank_c (
        .clock (clock),
        .reset (reset),
        .we    (write_en && (state_q == FILL_C)),
        .idx   (cnt_q),
        .wdata (in_row),
        .rows  (c_half_array)
    );

endmodule

// File: tb/tb_half_pel_array_collector.sv
// tb/tb_half_pel_array_collector.sv - scoreboard bench for half_pel_array_collector
module tb_half_pel_array_collector;

    localparam int NP = 8;
    localparam int RW = 120;
    localparam int AW = NP * RW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          first_round = 1'b0;
    logic          in_valid = 1'b0;
    logic [RW-1:0] in_row = '0;
    logic [7:0]    in_sel = '0;
    logic          in_ready, done, sel_err;
    logic [AW-1:0] a_half_array, b_half_array, c_half_array;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_arr [3];

    typedef struct {
        int            ph;
        int            row;
        logic [RW-1:0] val;
    } sb_t;
    sb_t sb_q [$];

    half_pel_array_collector #(.NUM_PIXEL(NP), .ROW_W(RW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .first_round  (first_round),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_sel       (in_sel),
        .a_half_array (a_half_array),
        .b_half_array (b_half_array),
        .c_half_array (c_half_array),
        .done         (done),
        .sel_err      (sel_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] dut_arr(input int ph);
        case (ph)
            0:       return a_half_array;
            1:       return b_half_array;
            default: return c_half_array;
        endcase
    endfunction

    function automatic logic [RW-1:0] dut_row(input int ph, input int row);
        logic [AW-1:0] arr;
        arr = dut_arr(ph);
        return arr[RW*row +: RW];
    endfunction

    task automatic model_write(input int ph, input int row, input logic [RW-1:0] v);
        sb_t e;
        exp_arr[ph][RW*row +: RW] = v;
        e.ph = ph;
        e.row = row;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int p = 0; p < 3; p++) exp_arr[p] = '0;
        sb_q.delete();
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got=%0b expected=%0b", name, act, req);
        end
    endtask

    task automatic drain_sb(input string name);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            if (dut_row(e.ph, e.row) !== e.val) begin
                miscompares++;
                $display("FAIL %s arr%0d row%0d got=%h expected=%h", name, e.ph, e.row,
                         dut_row(e.ph, e.row), e.val);
            end
        end
    endtask

    task automatic check_arrays(input string name);
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (dut_arr(p) !== exp_arr[p]) begin
                miscompares++;
                $display("FAIL %s arr%0d differs got_row0=%h expected_row0=%h", name, p,
                         dut_row(p, 0), exp_arr[p][RW-1:0]);
            end
        end
    endtask

    task automatic do_start(input logic fr);
        start = 1'b1;
        first_round = fr;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [RW-1:0] v, input logic [7:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_row = v;
        in_sel = tag;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_ready_timeout got=%0b expected=1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic fr, input int first, input int last,
                        input logic [RW-1:0] base, input bit gaps);
        int ph, row;
        logic [7:0] tag;
        for (int i = first; i <= last; i++) begin
            ph = fr ? i / NP : 1;
            row = i % NP;
            tag = 8'(row + 8 * ph);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clock);
                    check_bit("in_ready_gap", in_ready, 1'b1);
                end
            end
            send_beat(base + RW'(tag), tag);
            model_write(ph, row, base + RW'(tag));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_arrays("reset_arrays");
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_sel_err", sel_err, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_row = '1;
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        check_arrays("idle_ignore_arrays");
        check_bit("idle_in_ready", in_ready, 1'b0);
    endtask

    task automatic test_first_round();
        do_start(1'b1);
        check_bit("fr_in_ready_after_start", in_ready, 1'b1);
        feed(1'b1, 0, 22, '0, 1'b0);
        check_bit("fr_done_before_last", done, 1'b0);
        feed(1'b1, 23, 23, '0, 1'b0);
        check_bit("fr_done_after_last", done, 1'b1);
        drain_sb("fr_rows");
        check_arrays("fr_arrays");
    endtask

    task automatic test_done_ignore();
        in_valid = 1'b1;
        in_row = {RW{1'b1}};
        in_sel = 8'd0;
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        check_arrays("done_ignore_arrays");
        check_bit("done_hold", done, 1'b1);
        check_bit("done_in_ready", in_ready, 1'b0);
    endtask

    task automatic test_second_round();
        do_start(1'b0);
        check_bit("sr_done_cleared", done, 1'b0);
        feed(1'b0, 0, 7, RW'(120'h1000), 1'b0);
        check_bit("sr_done_after_8", done, 1'b1);
        drain_sb("sr_rows");
        check_arrays("sr_arrays");
    endtask

    task automatic test_random_valid();
        do_start(1'b1);
        feed(1'b1, 0, 23, RW'(120'hABC000), 1'b1);
        check_bit("rv_done", done, 1'b1);
        drain_sb("rv_rows");
        check_arrays("rv_arrays");
    endtask

    task automatic test_start_priority();
        do_start(1'b1);
        feed(1'b1, 0, 12, RW'(120'h7700), 1'b0);
        drain_sb("sp_rows");
        start = 1'b1;
        first_round = 1'b1;
        in_valid = 1'b1;
        in_row = RW'(120'hDEAD);
        in_sel = 8'd13;
        @(negedge clock);
        start = 1'b0;
        in_valid = 1'b0;
        check_arrays("sp_beat_dropped");
        check_bit("sp_in_ready", in_ready, 1'b1);
        check_bit("sp_done", done, 1'b0);
        send_beat(RW'(120'hBEEF), 8'd0);
        model_write(0, 0, RW'(120'hBEEF));
        send_beat(RW'(120'hCAFE), 8'd1);
        model_write(0, 1, RW'(120'hCAFE));
        drain_sb("sp_restart_rows");
        check_arrays("sp_arrays");
    endtask

    task automatic test_reset_mid_c();
        do_start(1'b1);
        feed(1'b1, 0, 18, RW'(120'h3300), 1'b0);
        drain_sb("rc_rows");
        in_valid = 1'b1;
        in_row = RW'(120'h1);
        in_sel = 8'd19;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_arrays("rc_async_arrays");
        check_bit("rc_async_done", done, 1'b0);
        check_bit("rc_async_in_ready", in_ready, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        check_arrays("rc_post_release_arrays");
        check_bit("rc_post_release_done", done, 1'b0);
    endtask

    task automatic test_sel_check();
        do_start(1'b1);
        feed(1'b1, 0, 2, RW'(120'h5000), 1'b0);
        send_beat(RW'(120'h9999), 8'd9);
`ifdef HALF_PEL_SEL_CHECK_EN
        check_bit("sc_sel_err_set", sel_err, 1'b1);
        check_arrays("sc_row3_unwritten");
        feed(1'b1, 3, 23, RW'(120'h5000), 1'b0);
        check_bit("sc_done", done, 1'b1);
        check_bit("sc_sel_err_sticky", sel_err, 1'b1);
        drain_sb("sc_rows");
        check_arrays("sc_arrays");
        do_start(1'b0);
        check_bit("sc_sel_err_cleared", sel_err, 1'b0);
`else
        model_write(0, 3, RW'(120'h9999));
        check_bit("sc_sel_err_tied", sel_err, 1'b0);
        feed(1'b1, 4, 23, RW'(120'h5000), 1'b0);
        check_bit("sc_done", done, 1'b1);
        drain_sb("sc_rows");
        check_arrays("sc_arrays");
`endif
    endtask

    initial begin
        model_clear();
        @(negedge clock);
        test_reset();
        test_first_round();
        test_done_ignore();
        test_second_round();
        test_random_valid();
        test_start_priority();
        test_reset_mid_c();
        test_sel_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/half_pel_array_collector.md
HALF_PEL_ARRAY_COLLECTOR -- requirements
Module: half_pel_array_collector

Interface
REQ-001 SHALL have parameter NUM_PIXEL, default 8: rows per half-pel array.
REQ-002 SHALL have parameter ROW_W, default 120: bits per row (15 pixels x 8 bits).
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a collection pass.
REQ-006 SHALL have port first_round, input, 1: sampled on start; 1 = collect A, B, C; 0 = collect B only.
REQ-007 SHALL have port in_valid, input, 1: filter row beat valid.
REQ-008 SHALL have port in_ready, output, 1: collector can accept a beat.
REQ-009 SHALL have port in_row, input, ROW_W: one filtered row.
REQ-010 SHALL have port in_sel, input, 8: row tag from the filter path.
REQ-011 SHALL have ports a_half_array, b_half_array, c_half_array, output, NUM_PIXEL*ROW_W (960) each: row k at bits [ROW_W*k +: ROW_W].
REQ-012 SHALL have port done, output, 1: the pass is complete and the arrays are stable.
REQ-013 SHALL have port sel_err, output, 1: sticky tag-mismatch flag.

Function
REQ-014 SHALL implement FSM states IDLE, FILL_A, FILL_B, FILL_C, DONE, with a 3-bit row counter cnt.
REQ-015 SHALL, on start in any state, clear cnt and sel_err, hold the array contents, and enter FILL_A if first_round=1, else FILL_B.
REQ-016 SHALL drive in_ready=1 only in FILL_A/B/C; a beat is accepted when in_valid & in_ready.
REQ-017 SHALL, on an accepted beat, write in_row to row cnt of the current array on that edge and increment cnt (zero latency; the row is visible the next cycle).
REQ-018 SHALL, on the accepted beat with cnt=NUM_PIXEL-1, wrap cnt to 0 and transition as follows:
  - FILL_A -> FILL_B;
  - FILL_B -> FILL_C if the pass is first-round, else DONE;
  - FILL_C -> DONE.
REQ-019 SHALL hold done=1 in DONE until the next start; done=0 elsewhere.
REQ-020 SHALL give start priority over a beat presented in the same cycle; that beat is not written.
REQ-021 SHALL ignore in_valid in IDLE and DONE, with no array change.
REQ-022 SHALL leave rows not yet written in the current pass holding their previous values.

Reset
REQ-023 SHALL, on reset low, asynchronously force state=IDLE, cnt=0, all arrays=0, in_ready=0, done=0, sel_err=0.
REQ-024 SHALL abandon a pass in progress on reset with no partial completion; release of reset needs a new start.

Configuration
REQ-025 SHALL, with macro HALF_PEL_SEL_CHECK_EN defined, compare in_sel on each accepted beat against the expected tag:
  - expected tag = cnt + 8*phase, where phase A=0, B=1, C=2;
  - on mismatch, drop the beat (no write, no cnt advance) and set sel_err until the next start or reset.
REQ-026 SHALL, without HALF_PEL_SEL_CHECK_EN, ignore in_sel and tie sel_err to 0.

Structure
REQ-027 SHALL place the FSM state enum, PIXEL_SIZE, ROW_W and phase constants in the shared package half_pel_pkg.
REQ-028 SHALL use one sub-module, half_pel_row_bank, instantiated three times: an NUM_PIXEL x ROW_W register bank with write-enable and row index.

Verification
REQ-029 SHALL cover: reset low, then start with first_round=1 and 24 back-to-back beats with row value = tag -> A rows 0..7 = 0..7, B rows = 8..15, C rows = 16..23, done=1 one cycle after beat 24.
REQ-030 SHALL cover: start with first_round=0 and 8 beats -> only B written; done after beat 8; A and C unchanged.
REQ-031 SHALL cover: in_valid toggled 1/0 randomly during a first_round pass -> identical final arrays; in_ready=1 throughout FILL states.
REQ-032 SHALL cover: start asserted with in_valid on beat 5 of FILL_B -> that beat is not written; cnt=0; state FILL_A.
REQ-033 SHALL cover: reset asserted mid-FILL_C -> arrays zero, done=0 immediately, asynchronously.
REQ-034 SHALL cover, with HALF_PEL_SEL_CHECK_EN: beat 3 tagged 9 -> sel_err=1, row 3 unwritten, cnt stays 3; a correct retry completes the pass.
